atm_multi_acct_ctrl: RTL and testbench
======================================

Name: atm_multi_acct_ctrl

Overview:
Parametrised next-generation ATM session controller.
- Serves NUM_ACCT accounts, each with its own balance, PIN-failure block and daily withdrawal total.
- Dispenses cash note-by-note through a request/acknowledge handshake with the cash mechanism.
- Aborts stalled sessions on an inactivity timeout.
- Sits between the card/keypad front end and the note dispenser.

Parameters:
AMT_W, 16, width of amounts and balances
NUM_ACCT, 4, number of accounts
ACCT_W, 2, account index width; must be at least clog2(NUM_ACCT)
MAX_PIN_TRIES, 3, consecutive wrong PINs that block an account
INIT_BALANCE, 1000, reset balance of every account
DAILY_LIMIT, 500, maximum withdrawn per account between day_reset pulses
NOTE_VALUE, 100, value of one note
TIMEOUT_CYC, 64, inactivity cycles before abort

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
card_inserted  in  1  card present level
acct_id  in  ACCT_W  account on card; sampled at session start
pin_entered  in  1  PIN-submit strobe
pin_correct  in  1  PIN check result; valid with pin_entered
txn_valid  in  1  transaction-select strobe
transaction_choice  in  2  01 balance, 10 withdrawal, other = cancel
amount  in  AMT_W  withdrawal amount; valid with txn_valid
day_reset  in  1  one-cycle pulse clearing all daily totals
note_ack  in  1  dispenser accepted one note
note_req  out  1  request one note
balance  out  AMT_W  balance of active account (last session's account when idle)
balance_valid  out  1  one-cycle pulse on balance inquiry
state_indicator  out  3  current state code
warning_message  out  1  wrong PIN entered this session
card_blocked  out  1  account blocked
exceed_balance  out  1  withdrawal rejected: insufficient funds or zero amount
exceed_limit  out  1  withdrawal rejected: daily limit
bad_amount  out  1  withdrawal rejected: not a multiple of NOTE_VALUE
timeout_flag  out  1  session aborted on inactivity
card_eject  out  1  one-cycle eject pulse

Behaviour:
- Reset:
  - State IDLE.
  - All balances INIT_BALANCE; all daily totals 0; all block bits 0; PIN-try counter 0.
  - All outputs 0, except balance = INIT_BALANCE (account 0).
- Reset mid-session aborts immediately: no note_req, no eject pulse.
- State codes: IDLE 0, CARD_IN 1, CHECK_PIN 2, TXN_SEL 3, BAL_SHOW 4, WD_CHECK 5, DISPENSE 6, EJECT 7.
- IDLE:
  - Session starts only on a rising edge of card_inserted (registered previous value).
  - Latch acct_id; go to CARD_IN, or to EJECT with card_blocked if that account is blocked.
- CARD_IN: wait for pin_entered, then go to CHECK_PIN, which lasts one cycle and uses the pin_correct sampled with pin_entered.
  - Correct: tries = 0; go to TXN_SEL.
  - Wrong: tries + 1; warning_message = 1.
  - If tries + 1 == MAX_PIN_TRIES: set account block bit, card_blocked = 1, go to EJECT. Otherwise return to CARD_IN.
- TXN_SEL: wait for txn_valid.
  - 01: go to BAL_SHOW (balance_valid for one cycle), then EJECT.
  - 10: go to WD_CHECK.
  - Other: go to EJECT.
- WD_CHECK (one cycle), rules checked in priority order:
  1. amount == 0 or amount > balance: exceed_balance.
  2. amount % NOTE_VALUE != 0: bad_amount.
  3. daily_total + amount > DAILY_LIMIT, computed at AMT_W+1 bits: exceed_limit.
  - Any failure goes to EJECT. Otherwise load remaining = amount and go to DISPENSE.
- DISPENSE:
  - note_req is held high while remaining != 0.
  - Each cycle with note_req and note_ack both high:
    - remaining −= NOTE_VALUE;
    - balance −= NOTE_VALUE;
    - daily_total += NOTE_VALUE.
  - remaining reaching 0 drops note_req on the next cycle; go to EJECT.
- Inactivity timer:
  - Counts in CARD_IN, TXN_SEL and DISPENSE.
  - Cleared on state entry, on pin_entered, on txn_valid and on note_ack.
  - At count == TIMEOUT_CYC−1, go to EJECT with timeout_flag.
  - A timeout in DISPENSE keeps debits for notes already acked; the partial withdrawal stands.
- EJECT: lasts exactly one cycle with card_eject = 1, then IDLE. The session PIN-try counter clears.
- Flags:
  - exceed_balance, exceed_limit, bad_amount and timeout_flag are registered. They are high exactly during the EJECT cycle caused by them.
  - warning_message stays high from the first wrong PIN until EJECT exits.
  - card_blocked is high during EJECT of a blocking session, or of a rejected session start.
- Block bits persist until reset; day_reset does not clear them.
- day_reset:
  - Clears every account's daily total.
  - If it coincides with an acked note, the total for that account becomes NOTE_VALUE (clear, then add).
- Simultaneous events:
  - pin_entered in any state other than CARD_IN is ignored; the same holds for txn_valid outside TXN_SEL and note_ack outside DISPENSE.
  - card_inserted falling mid-session has no effect; the timeout handles abandonment.

Test Plan:
- Account 2, correct PIN, withdraw 300; note_ack on every other cycle → 3 note_req/ack pairs, balance 700, eject; a later balance inquiry shows balance_valid with 700.
- Account 1, three wrong PINs → warning_message after the first; on the third, card_blocked and eject. A new session on account 1 ejects immediately with card_blocked; account 0 still works.
- Account 0: withdraw 400 (ok), new session withdraw 200 → exceed_limit, balance 600. Pulse day_reset, withdraw 200 → ok, balance 400.
- Withdraw 150 → bad_amount. Withdraw 1200 → exceed_balance. Withdraw 0 → exceed_balance. Balance unchanged in all three.
- Withdraw 300, ack one note then hold note_ack low for 64 cycles → timeout_flag, balance 900, daily total 100. Idle in TXN_SEL for 64 cycles → timeout eject.
- Assert reset mid-DISPENSE after one ack → note_req drops at once; all balances 1000, block bits clear; no eject pulse.

Source files
------------

// File: rtl/atm_multi_acct_ctrl.sv
// ATM session controller: per-account balances, PIN blocking and daily limits,
// note-by-note dispensing over a req/ack handshake, and inactivity abort.
module atm_multi_acct_ctrl #(
  parameter int AMT_W         = 16,
  parameter int NUM_ACCT      = 4,
  parameter int ACCT_W        = 2,
  parameter int MAX_PIN_TRIES = 3,
  parameter int INIT_BALANCE  = 1000,
  parameter int DAILY_LIMIT   = 500,
  parameter int NOTE_VALUE    = 100,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              card_inserted,
  input  logic [ACCT_W-1:0] acct_id,
  input  logic              pin_entered,
  input  logic              pin_correct,
  input  logic              txn_valid,
  input  logic [1:0]        transaction_choice,
  input  logic [AMT_W-1:0]  amount,
  input  logic              day_reset,
  input  logic              note_ack,
  output logic              note_req,
  output logic [AMT_W-1:0]  balance,
  output logic              balance_valid,
  output logic [2:0]        state_indicator,
  output logic              warning_message,
  output logic              card_blocked,
  output logic              exceed_balance,
  output logic              exceed_limit,
  output logic              bad_amount,
  output logic              timeout_flag,
  output logic              card_eject
);

  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [AMT_W-1:0] NOTE  = AMT_W'(NOTE_VALUE);
  localparam logic [AMT_W:0]   LIMIT = (AMT_W+1)'(DAILY_LIMIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CARD_IN   = 3'd1,
    CHECK_PIN = 3'd2,
    TXN_SEL   = 3'd3,
    BAL_SHOW  = 3'd4,
    WD_CHECK  = 3'd5,
    DISPENSE  = 3'd6,
    EJECT     = 3'd7
  } state_t;

  state_t state, state_next;

  logic [AMT_W-1:0]    bal_mem   [NUM_ACCT];
  logic [AMT_W-1:0]    daily_mem [NUM_ACCT];
  logic [NUM_ACCT-1:0] blocked;
  logic [ACCT_W-1:0]   acct;
  logic                card_prev;
  logic                pin_ok;
  logic [AMT_W-1:0]    amt_q;
  logic [AMT_W-1:0]    remaining;
  logic [TRY_W-1:0]    tries;
  logic [TMR_W-1:0]    timer;

  logic             card_rise, ack, counting, activity, timed_out;
  logic             set_blocked, set_warn, set_exc_bal, set_bad_amt, set_exc_lim;
  logic             block_acct;
  logic [AMT_W-1:0] cur_bal, cur_daily;
  logic [AMT_W:0]   daily_sum;

  assign cur_bal   = bal_mem[acct];
  assign cur_daily = daily_mem[acct];
  assign daily_sum = {1'b0, cur_daily} + {1'b0, amt_q};
  assign card_rise = card_inserted & ~card_prev;

  assign note_req        = (state == DISPENSE) && (remaining != '0);
  assign ack             = note_req & note_ack;
  assign balance         = cur_bal;
  assign balance_valid   = (state == BAL_SHOW);
  assign card_eject      = (state == EJECT);
  assign state_indicator = state;

  // Only events that the current state actually consumes restart the timer.
  assign counting  = state inside {CARD_IN, TXN_SEL, DISPENSE};
  assign activity  = ((state == CARD_IN) && pin_entered) ||
                     ((state == TXN_SEL) && txn_valid) || ack;
  assign timed_out = counting && !activity && (timer == TMR_W'(TIMEOUT_CYC - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    set_blocked = 1'b0;
    set_warn    = 1'b0;
    set_exc_bal = 1'b0;
    set_bad_amt = 1'b0;
    set_exc_lim = 1'b0;
    block_acct  = 1'b0;
    case (state)
      IDLE: begin
        if (card_rise) begin
          if (blocked[acct_id]) begin
            state_next  = EJECT;
            set_blocked = 1'b1;
          end else begin
            state_next = CARD_IN;
          end
        end
      end
      CARD_IN:   if (pin_entered) state_next = CHECK_PIN;
      CHECK_PIN: begin
        if (pin_ok) begin
          state_next = TXN_SEL;
        end else begin
          set_warn = 1'b1;
          if (tries == TRY_W'(MAX_PIN_TRIES - 1)) begin
            block_acct  = 1'b1;
            set_blocked = 1'b1;
            state_next  = EJECT;
          end else begin
            state_next = CARD_IN;
          end
        end
      end
      TXN_SEL: begin
        if (txn_valid) begin
          case (transaction_choice)
            2'b01:   state_next = BAL_SHOW;
            2'b10:   state_next = WD_CHECK;
            default: state_next = EJECT;
          endcase
        end
      end
      BAL_SHOW: state_next = EJECT;
      WD_CHECK: begin
        state_next = EJECT;
        if ((amt_q == '0) || (amt_q > cur_bal)) set_exc_bal = 1'b1;
        else if ((amt_q % NOTE) != '0)          set_bad_amt = 1'b1;
        else if (daily_sum > LIMIT)             set_exc_lim = 1'b1;
        else                                    state_next  = DISPENSE;
      end
      // The last acked note ends the session directly; note_req is low in EJECT.
      DISPENSE: if (ack && (remaining == NOTE)) state_next = EJECT;
      EJECT:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (timed_out) state_next = EJECT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      card_prev <= 1'b0;
      acct      <= '0;
      pin_ok    <= 1'b0;
      amt_q     <= '0;
      remaining <= '0;
      tries     <= '0;
      timer     <= '0;
    end else begin
      state     <= state_next;
      card_prev <= card_inserted;
      if ((state == IDLE) && card_rise)      acct   <= acct_id;
      if ((state == CARD_IN) && pin_entered) pin_ok <= pin_correct;
      if ((state == TXN_SEL) && txn_valid)   amt_q  <= amount;

      if ((state == WD_CHECK) && (state_next == DISPENSE)) remaining <= amt_q;
      else if (ack)                                         remaining <= remaining - NOTE;

      if (state == EJECT)          tries <= '0;
      else if (state == CHECK_PIN) tries <= pin_ok ? '0 : tries + 1'b1;

      if ((state_next != state) || activity || !counting) timer <= '0;
      else                                                timer <= timer + 1'b1;
    end
  end

  // NOTE: the account arrays are reset deliberately: their reset contents are architectural state, not scratch storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blocked <= '0;
      for (int i = 0; i < NUM_ACCT; i++) begin
        bal_mem[i]   <= AMT_W'(INIT_BALANCE);
        daily_mem[i] <= '0;
      end
    end else begin
      if (block_acct) blocked[acct] <= 1'b1;
      for (int i = 0; i < NUM_ACCT; i++) begin
        if (ack && (acct == ACCT_W'(i))) bal_mem[i] <= bal_mem[i] - NOTE;
        // day_reset clears first; a coincident acked note then counts toward the new day.
        if (day_reset)
          daily_mem[i] <= (ack && (acct == ACCT_W'(i))) ? NOTE : '0;
        else if (ack && (acct == ACCT_W'(i)))
          daily_mem[i] <= daily_mem[i] + NOTE;
      end
    end
  end

  // Session flags: set by the event that causes them, cleared as EJECT exits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warning_message <= 1'b0;
      card_blocked    <= 1'b0;
      exceed_balance  <= 1'b0;
      exceed_limit    <= 1'b0;
      bad_amount      <= 1'b0;
      timeout_flag    <= 1'b0;
    end else if (state == EJECT) begin
      warning_message <= 1'b0;
      card_blocked    <= 1'b0;
      exceed_balance  <= 1'b0;
      exceed_limit    <= 1'b0;
      bad_amount      <= 1'b0;
      timeout_flag    <= 1'b0;
    end else begin
      if (set_warn)    warning_message <= 1'b1;
      if (set_blocked) card_blocked    <= 1'b1;
      if (set_exc_bal) exceed_balance  <= 1'b1;
      if (set_exc_lim) exceed_limit    <= 1'b1;
      if (set_bad_amt) bad_amount      <= 1'b1;
      if (timed_out)   timeout_flag    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_atm_multi_acct_ctrl.sv
// Scoreboard bench for atm_multi_acct_ctrl: stimulus tasks push expected session
// outcomes from an account-level model; a monitor compares them on balance_valid / card_eject.
module tb_atm_multi_acct_ctrl;

  localparam int AMT_W     = 16;
  localparam int NUM_ACCT  = 4;
  localparam int ACCT_W    = 2;
  localparam int MAX_TRIES = 3;
  localparam int INIT_BAL  = 1000;
  localparam int LIMIT     = 500;
  localparam int NOTE      = 100;
  localparam int TIMEOUT   = 64;

  localparam logic [2:0] S_IDLE = 3'd0, S_CARD_IN = 3'd1, S_CHECK_PIN = 3'd2, S_TXN_SEL = 3'd3;
  localparam logic [2:0] S_DISPENSE = 3'd6, S_EJECT = 3'd7;

  // Flag vector order: exceed_balance, bad_amount, exceed_limit, timeout_flag, card_blocked, warning_message
  localparam logic [5:0] F_EXB = 6'b100000, F_BAD = 6'b010000, F_LIM = 6'b001000;
  localparam logic [5:0] F_TMO = 6'b000100, F_BLK = 6'b000010, F_WARN = 6'b000001;

  localparam int K_CANCEL = 0, K_BAL = 1, K_WD = 2, K_IDLE = 3;

  typedef struct {
    bit          is_bal;
    int unsigned bal;
    logic [5:0]  flags;
    int          notes;
  } exp_t;

  logic              clk, reset;
  logic              card_inserted, pin_entered, pin_correct, txn_valid, day_reset, note_ack;
  logic [ACCT_W-1:0] acct_id;
  logic [1:0]        transaction_choice;
  logic [AMT_W-1:0]  amount;
  logic              note_req, balance_valid, warning_message, card_blocked;
  logic              exceed_balance, exceed_limit, bad_amount, timeout_flag, card_eject;
  logic [AMT_W-1:0]  balance;
  logic [2:0]        state_indicator;

  exp_t        exp_q[$];
  exp_t        got;
  int          n_checks = 0;
  int          n_err = 0;
  int          notes_seen = 0;
  int unsigned m_bal   [NUM_ACCT];
  int unsigned m_daily [NUM_ACCT];
  bit          m_blk   [NUM_ACCT];

  atm_multi_acct_ctrl #(
    .AMT_W(AMT_W), .NUM_ACCT(NUM_ACCT), .ACCT_W(ACCT_W), .MAX_PIN_TRIES(MAX_TRIES),
    .INIT_BALANCE(INIT_BAL), .DAILY_LIMIT(LIMIT), .NOTE_VALUE(NOTE), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .card_inserted(card_inserted), .acct_id(acct_id),
    .pin_entered(pin_entered), .pin_correct(pin_correct), .txn_valid(txn_valid),
    .transaction_choice(transaction_choice), .amount(amount), .day_reset(day_reset),
    .note_ack(note_ack), .note_req(note_req), .balance(balance), .balance_valid(balance_valid),
    .state_indicator(state_indicator), .warning_message(warning_message),
    .card_blocked(card_blocked), .exceed_balance(exceed_balance), .exceed_limit(exceed_limit),
    .bad_amount(bad_amount), .timeout_flag(timeout_flag), .card_eject(card_eject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every session-visible output event is matched against the queue head.
  always @(negedge clk) begin
    if (reset) begin
      notes_seen = 0;
    end else begin
      if (note_req && note_ack) notes_seen++;
      if (balance_valid || card_eject) begin
        if (exp_q.size() == 0) begin
          check("spurious_output_event", 1, 0);
        end else begin
          got = exp_q.pop_front();
          if (balance_valid) begin
            check("event_is_inquiry", {31'd0, got.is_bal}, 1);
            check("inquiry_balance", balance, got.bal);
          end else begin
            check("event_is_eject", {31'd0, got.is_bal}, 0);
            check("eject_flags", {exceed_balance, bad_amount, exceed_limit, timeout_flag,
                                  card_blocked, warning_message}, got.flags);
            check("eject_balance", balance, got.bal);
            check("notes_dispensed", notes_seen, got.notes);
            notes_seen = 0;
          end
        end
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_ACCT; i++) begin
      m_bal[i] = INIT_BAL;
      m_daily[i] = 0;
      m_blk[i] = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget, input string name);
    int n = 0;
    while (state_indicator !== code && n < budget) begin
      tick();
      n++;
    end
    check(name, state_indicator, code);
  endtask

  task automatic pulse_pin(input logic ok);
    pin_entered = 1'b1;
    pin_correct = ok;
    tick();
    pin_entered = 1'b0;
    pin_correct = 1'b0;
  endtask

  task automatic pulse_txn(input logic [1:0] ch, input int amt);
    txn_valid = 1'b1;
    transaction_choice = ch;
    amount = amt[AMT_W-1:0];
    tick();
    txn_valid = 1'b0;
    transaction_choice = 2'b00;
    amount = '0;
  endtask

  task automatic pulse_day_reset();
    day_reset = 1'b1;
    tick();
    day_reset = 1'b0;
    for (int i = 0; i < NUM_ACCT; i++) m_daily[i] = 0;
  endtask

  task automatic finish_session();
    wait_state(S_EJECT, 300, "reach_eject");
    wait_state(S_IDLE, 4, "reach_idle");
    card_inserted = 1'b0;
    tick();
  endtask

  // One full session. The model decides the outcome first and queues it, then the bus is driven.
  task automatic session(input int a, input int wrong, input int kind, input int amt,
                         input int ack_mode, input int stall_after, input int dr_at);
    exp_t e;
    int   tries, notes, acked, given, gap, guard, n;
    bit   go;
    e = '{is_bal: 1'b0, bal: 0, flags: 6'b0, notes: 0};
    tries = 0;
    card_inserted = 1'b1;
    acct_id = a[ACCT_W-1:0];
    if (m_blk[a]) begin
      e.flags = F_BLK;
      e.bal = m_bal[a];
      exp_q.push_back(e);
      finish_session();
      return;
    end
    for (int k = 0; k < wrong; k++) begin
      wait_state(S_CARD_IN, 8, "reach_card_in");
      pulse_pin(1'b0);
      tries++;
      e.flags |= F_WARN;
      if (tries == MAX_TRIES) begin
        m_blk[a] = 1'b1;
        e.flags |= F_BLK;
        e.bal = m_bal[a];
        exp_q.push_back(e);
        finish_session();
        return;
      end
      wait_state(S_CARD_IN, 8, "reach_card_in_retry");
      check("warning_after_wrong_pin", warning_message, 1);
    end
    wait_state(S_CARD_IN, 8, "reach_card_in");
    pulse_pin(1'b1);
    wait_state(S_TXN_SEL, 8, "reach_txn_sel");
    check("warning_in_txn_sel", warning_message, {31'd0, e.flags[0]});
    card_inserted = ($urandom_range(0, 1) == 1);  // card level mid-session must not matter
    case (kind)
      K_BAL: begin
        exp_q.push_back('{is_bal: 1'b1, bal: m_bal[a], flags: 6'b0, notes: 0});
        e.bal = m_bal[a];
        exp_q.push_back(e);
        pulse_txn(2'b01, 0);
      end
      K_IDLE: begin
        e.flags |= F_TMO;
        e.bal = m_bal[a];
        exp_q.push_back(e);
        n = 0;
        while (state_indicator === S_TXN_SEL && n < 200) begin
          tick();
          n++;
        end
        check("txn_sel_timeout_cycles", n, TIMEOUT);
      end
      K_WD: begin
        acked = 0;
        if (amt == 0 || amt > int'(m_bal[a]))        e.flags |= F_EXB;
        else if (amt % NOTE != 0)                    e.flags |= F_BAD;
        else if (int'(m_daily[a]) + amt > LIMIT)     e.flags |= F_LIM;
        else begin
          notes = amt / NOTE;
          acked = (stall_after >= 0 && stall_after < notes) ? stall_after : notes;
          for (int k = 0; k < acked; k++) begin
            if (k == dr_at) begin
              for (int i = 0; i < NUM_ACCT; i++) m_daily[i] = 0;
              m_daily[a] = NOTE;
            end else begin
              m_daily[a] += NOTE;
            end
            m_bal[a] -= NOTE;
          end
          if (acked < notes) e.flags |= F_TMO;
          e.notes = acked;
        end
        e.bal = m_bal[a];
        exp_q.push_back(e);
        pulse_txn(2'b10, amt);
        if (e.flags[5:3] == 3'b000) begin
          wait_state(S_DISPENSE, 4, "reach_dispense");
          given = 0; gap = 0; guard = 0;
          while (given < acked && guard < 200) begin
            case (ack_mode)
              0:       go = 1'b1;
              1:       go = (guard % 2 == 1);
              default: go = ($urandom_range(0, 1) == 1) || gap >= 3;
            endcase
            note_ack = go;
            day_reset = go && (given == dr_at);
            tick();
            if (go) begin
              given++;
              gap = 0;
            end else begin
              gap++;
            end
            guard++;
          end
          note_ack = 1'b0;
          day_reset = 1'b0;
        end
      end
      default: begin
        e.bal = m_bal[a];
        exp_q.push_back(e);
        pulse_txn(amt[1:0], 0);
      end
    endcase
    finish_session();
  endtask

  initial begin
    int a, wrong, kind, amt, r;
    reset = 1'b1;
    card_inserted = 1'b0; acct_id = '0; pin_entered = 1'b0; pin_correct = 1'b0;
    txn_valid = 1'b0; transaction_choice = 2'b00; amount = '0; day_reset = 1'b0; note_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("reset_outputs", {state_indicator, note_req, balance_valid, warning_message, card_blocked,
                            exceed_balance, exceed_limit, bad_amount, timeout_flag, card_eject}, 0);
    check("reset_balance", balance, INIT_BAL);

    // Account 2: withdraw 300 with acks on alternate cycles, then inquiry.
    session(2, 0, K_WD, 300, 1, -1, -1);
    session(2, 0, K_BAL, 0, 0, -1, -1);
    // Account 1 blocked by three wrong PINs; account 0 unaffected.
    session(1, 3, K_BAL, 0, 0, -1, -1);
    session(1, 0, K_BAL, 0, 0, -1, -1);
    session(0, 1, K_BAL, 0, 0, -1, -1);
    // Daily limit and day_reset on account 0.
    session(0, 0, K_WD, 400, 2, -1, -1);
    session(0, 0, K_WD, 200, 0, -1, -1);
    pulse_day_reset();
    session(0, 0, K_WD, 200, 0, -1, -1);
    // Rejections on account 3, plus an explicit cancel code.
    session(3, 0, K_WD, 150, 0, -1, -1);
    session(3, 0, K_WD, 1200, 0, -1, -1);
    session(3, 0, K_WD, 0, 0, -1, -1);
    session(3, 0, K_CANCEL, 3, 0, -1, -1);
    // Stall after one note; the partial debit and daily total stand; limit boundary at exactly 500.
    session(3, 0, K_WD, 300, 0, 1, -1);
    session(3, 0, K_WD, 500, 0, -1, -1);
    session(3, 0, K_WD, 400, 0, -1, -1);
    session(3, 2, K_IDLE, 0, 0, -1, -1);
    // day_reset coinciding with the last acked note of account 2.
    session(2, 0, K_WD, 200, 0, -1, 1);
    session(2, 0, K_WD, 500, 0, -1, -1);
    session(2, 0, K_WD, 400, 0, -1, -1);

    // Reset in the middle of a dispense after one acked note.
    pulse_day_reset();
    card_inserted = 1'b1;
    acct_id = 2'd0;
    wait_state(S_CARD_IN, 8, "reach_card_in");
    pulse_pin(1'b1);
    wait_state(S_TXN_SEL, 8, "reach_txn_sel");
    pulse_txn(2'b10, 300);
    wait_state(S_DISPENSE, 4, "reach_dispense");
    note_ack = 1'b1;
    tick();
    note_ack = 1'b0;
    check("note_req_before_reset", note_req, 1);
    #2 reset = 1'b1;
    card_inserted = 1'b0;
    #1;
    check("note_req_on_reset", note_req, 0);
    check("state_on_reset", state_indicator, S_IDLE);
    check("no_eject_on_reset", card_eject, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    for (int i = 0; i < NUM_ACCT; i++) session(i, 0, K_BAL, 0, 0, -1, -1);

    // Randomised sessions against the account model.
    for (int s = 0; s < 40; s++) begin
      a = $urandom_range(0, NUM_ACCT - 1);
      wrong = ($urandom_range(0, 14) == 0) ? MAX_TRIES : $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      kind = (r < 2) ? K_BAL : (r == 2) ? K_CANCEL : K_WD;
      if (kind == K_CANCEL)                 amt = $urandom_range(0, 1) * 3;
      else if ($urandom_range(0, 4) == 0)   amt = $urandom_range(1, 1500);
      else                                  amt = $urandom_range(0, 6) * NOTE;
      session(a, wrong, kind, amt, $urandom_range(0, 2), -1,
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1);
      if ($urandom_range(0, 7) == 0) pulse_day_reset();
    end

    r = 0;
    while (exp_q.size() != 0 && r < 100) begin
      tick();
      r++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
